// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_core
// Description : Multi-cycle RV32I integer core (FETCH / DECODE / EXEC / HALT).
//               Owns the PC, instruction register, register file, decoder and
//               ALU. Fetches through a valid-qualified request interface and
//               halts on EBREAK or on an illegal instruction.
// Ports       : clk, rst        - clock / synchronous active-high reset
//               imem_req, pc    - fetch request (FETCH only) and current PC
//               inst, inst_valid- instruction word and its valid qualifier
//               retire          - one-cycle pulse per committed instruction
//               halt, illegal   - sticky halt status and illegal-cause flag
//               dbg_addr/data   - side-effect-free register-file read port
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_core #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] pc,
    input  logic [31:0]     inst,
    input  logic            inst_valid,
    output logic            retire,
    output logic            halt,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int              IDXW       = (NREG > 16) ? 5 : 4;
    localparam int              SHW        = $clog2(XLEN);
    localparam logic [5:0]      c_nreg     = 6'(NREG);
    localparam logic [6:0]      c_op_lui   = 7'b0110111;
    localparam logic [6:0]      c_op_auipc = 7'b0010111;
    localparam logic [6:0]      c_op_jal   = 7'b1101111;
    localparam logic [6:0]      c_op_jalr  = 7'b1100111;
    localparam logic [6:0]      c_op_imm   = 7'b0010011;
    localparam logic [6:0]      c_op_reg   = 7'b0110011;
    localparam logic [6:0]      c_op_sys   = 7'b1110011;
    localparam logic [31:0]     c_ebreak   = 32'h0010_0073;
    localparam logic [6:0]      c_f7_alt   = 7'b0100000;
    localparam logic [XLEN-1:0] c_clr_lsb  = {{(XLEN-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_imm;
    logic            r_halt;
    logic            r_illegal;
    logic [XLEN-1:0] r_regs [NREG];

    // Instruction fields (valid in DECODE and EXEC, both work from r_ir)
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [6:0]      w_f7;
    logic [6:0]      w_f7_shift;
    logic [31:0]     w_imm_i32;
    logic [31:0]     w_imm_u32;
    logic [31:0]     w_imm_j32;

    assign w_opcode  = r_ir[6:0];
    assign w_rd      = r_ir[11:7];
    assign w_f3      = r_ir[14:12];
    assign w_rs1     = r_ir[19:15];
    assign w_rs2     = r_ir[24:20];
    assign w_f7      = r_ir[31:25];
    assign w_imm_i32 = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_u32 = {r_ir[31:12], 12'b0};
    assign w_imm_j32 = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    // On wider datapaths bit 25 belongs to the shift amount, not funct7
    assign w_f7_shift = (SHW > 5) ? {w_f7[6:1], 1'b0} : w_f7;

    // ------------------------------------------------------------------
    // Decoder: legality, which register fields are live, immediate select
    // ------------------------------------------------------------------
    logic            w_legal;
    logic            w_use_rd;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_is_ebreak;
    logic            w_is_jump;
    logic [XLEN-1:0] w_imm;
    logic            w_idx_bad;
    logic            w_decode_ok;

    always_comb begin
        w_legal     = 1'b0;
        w_use_rd    = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_is_ebreak = 1'b0;
        w_is_jump   = 1'b0;
        w_imm       = XLEN'($signed(w_imm_i32));
        case (w_opcode)
            c_op_lui, c_op_auipc: begin
                w_legal  = 1'b1;
                w_use_rd = 1'b1;
                w_imm    = XLEN'($signed(w_imm_u32));
            end
            c_op_jal: begin
                w_legal   = 1'b1;
                w_use_rd  = 1'b1;
                w_is_jump = 1'b1;
                w_imm     = XLEN'($signed(w_imm_j32));
            end
            c_op_jalr: begin
                w_legal   = (w_f3 == 3'b000);
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_is_jump = 1'b1;
            end
            c_op_imm: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                case (w_f3)
                    3'b001:  w_legal = (w_f7_shift == 7'b0);
                    3'b101:  w_legal = (w_f7_shift == 7'b0) || (w_f7_shift == c_f7_alt);
                    default: w_legal = 1'b1;
                endcase
            end
            c_op_reg: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_legal   = (w_f7 == 7'b0) ||
                            ((w_f7 == c_f7_alt) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            c_op_sys: begin
                w_legal     = (r_ir == c_ebreak);
                w_is_ebreak = (r_ir == c_ebreak);
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_idx_bad   = (w_use_rd  && ({1'b0, w_rd}  >= c_nreg)) ||
                         (w_use_rs1 && ({1'b0, w_rs1} >= c_nreg)) ||
                         (w_use_rs2 && ({1'b0, w_rs2} >= c_nreg));
    assign w_decode_ok = w_legal && !w_idx_bad;

    // Register-file reads; x0 and out-of-range indices read as zero
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    assign w_rs1_val = ((w_rs1 != 5'd0) && ({1'b0, w_rs1} < c_nreg)) ? r_regs[w_rs1[IDXW-1:0]] : '0;
    assign w_rs2_val = ((w_rs2 != 5'd0) && ({1'b0, w_rs2} < c_nreg)) ? r_regs[w_rs2[IDXW-1:0]] : '0;
    assign dbg_data  = ((dbg_addr != 5'd0) && ({1'b0, dbg_addr} < c_nreg)) ?
                       r_regs[dbg_addr[IDXW-1:0]] : '0;

    // ------------------------------------------------------------------
    // EXEC datapath: ALU result, jump target, next PC
    // ------------------------------------------------------------------
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_tgt_raw;
    logic [XLEN-1:0] w_target;
    logic            w_misalign;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_result;

    assign w_shamt    = r_b[SHW-1:0];
    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_tgt_raw  = (w_opcode == c_op_jalr) ? (r_a + r_imm) : (r_pc + r_imm);
    assign w_target   = w_tgt_raw & c_clr_lsb;
    // Only 4-byte aligned targets are reachable without compressed support
    assign w_misalign = w_is_jump && w_target[1];
    assign w_next_pc  = w_is_jump ? w_target : w_pc_plus4;

    always_comb begin
        w_result = '0;
        case (w_opcode)
            c_op_lui:           w_result = r_imm;
            c_op_auipc:         w_result = r_pc + r_imm;
            c_op_jal, c_op_jalr: w_result = w_pc_plus4;
            c_op_imm, c_op_reg: begin
                case (w_f3)
                    3'b000:  w_result = ((w_opcode == c_op_reg) && r_ir[30]) ? (r_a - r_b) : (r_a + r_b);
                    3'b001:  w_result = r_a << w_shamt;
                    3'b010:  w_result = XLEN'($signed(r_a) < $signed(r_b));
                    3'b011:  w_result = XLEN'(r_a < r_b);
                    3'b100:  w_result = r_a ^ r_b;
                    3'b101:  w_result = r_ir[30] ? XLEN'($signed(r_a) >>> w_shamt) : (r_a >> w_shamt);
                    3'b110:  w_result = r_a | r_b;
                    default: w_result = r_a & r_b;
                endcase
            end
            default:            w_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        retire      = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (inst_valid) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_nxt = w_decode_ok ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                // A misaligned jump is not committed, so it does not retire
                if (w_misalign) begin
                    w_state_nxt = S_HALT;
                end else begin
                    retire      = 1'b1;
                    w_state_nxt = w_is_ebreak ? S_HALT : S_FETCH;
                end
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // PC, IR, operand latches and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_halt    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (inst_valid) begin
                        r_ir <= inst;
                    end
                end
                S_DECODE: begin
                    r_a   <= w_rs1_val;
                    r_b   <= (w_opcode == c_op_reg) ? w_rs2_val : w_imm;
                    r_imm <= w_imm;
                    if (!w_decode_ok) begin
                        r_halt    <= 1'b1;
                        r_illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_misalign) begin
                        r_halt    <= 1'b1;
                        r_illegal <= 1'b1;
                    end else if (w_is_ebreak) begin
                        r_halt <= 1'b1;
                    end else begin
                        r_pc <= w_next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file: write-back at the end of EXEC, x0 never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if ((r_state == S_EXEC) && !w_misalign && w_use_rd && (w_rd != 5'd0)) begin
            r_regs[w_rd[IDXW-1:0]] <= w_result;
        end
    end

    assign pc      = r_pc;
    assign halt    = r_halt;
    assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_core
// Description : Self-checking bench for multicycle_core. An instruction-level
//               model (architectural registers, PC, halt status) predicts each
//               instruction's effect; directed cases plus randomized RV32I
//               instructions with random fetch stalls are compared cycle by
//               cycle against the core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_core;

    localparam logic [31:0] c_reset_pc = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        retire;
    logic        halt;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Architectural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_illegal;

    multicycle_core #(
        .XLEN     (32),
        .NREG     (32),
        .RESET_PC (c_reset_pc)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .retire     (retire),
        .halt       (halt),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic dbg_check(input string tag, input logic [4:0] a);
        dbg_addr = a;
        #1;
        check_eq(tag, dbg_data, m_regs[a]);
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    // Instruction-set model. kind: 0 commit, 1 ebreak, 2 illegal encoding,
    // 3 misaligned jump target.
    function automatic void model_step(input logic [31:0] w, output int kind,
                                       output logic [4:0] rd, output logic wr,
                                       output logic [31:0] val, output logic [31:0] npc);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b, imm_i, imm_u, imm_j, t;
        op    = w[6:0];
        rd    = w[11:7];
        f3    = w[14:12];
        f7    = w[31:25];
        a     = m_regs[w[19:15]];
        imm_i = {{20{w[31]}}, w[31:20]};
        imm_u = {w[31:12], 12'b0};
        imm_j = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        b     = (op == 7'h33) ? m_regs[w[24:20]] : imm_i;
        kind  = 0;
        wr    = 1'b0;
        val   = 32'h0;
        npc   = m_pc + 32'd4;
        case (op)
            7'h37: begin wr = 1'b1; val = imm_u; end
            7'h17: begin wr = 1'b1; val = m_pc + imm_u; end
            7'h6F: begin
                t = m_pc + imm_j;
                if (t[1]) kind = 3;
                else begin wr = 1'b1; val = m_pc + 32'd4; npc = t; end
            end
            7'h67: begin
                t = (a + imm_i) & 32'hFFFF_FFFE;
                if (f3 != 3'd0) kind = 2;
                else if (t[1]) kind = 3;
                else begin wr = 1'b1; val = m_pc + 32'd4; npc = t; end
            end
            7'h13, 7'h33: begin
                wr = 1'b1;
                if (op == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) kind = 2;
                if (op == 7'h13 && f3 == 3'd1 && f7 != 7'h00) kind = 2;
                if (op == 7'h13 && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) kind = 2;
                case (f3)
                    3'd0: val = (op == 7'h33 && f7 == 7'h20) ? a - b : a + b;
                    3'd1: val = a << b[4:0];
                    3'd2: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: val = (a < b) ? 32'd1 : 32'd0;
                    3'd4: val = a ^ b;
                    3'd5: val = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'd6: val = a | b;
                    default: val = a & b;
                endcase
            end
            7'h73: kind = (w == 32'h0010_0073) ? 1 : 2;
            default: kind = 2;
        endcase
        if (kind != 0) wr = 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc      = c_reset_pc;
        m_halted  = 1'b0;
        m_illegal = 1'b0;
    endtask

    // Called at a falling edge; leaves the core in FETCH at a falling edge
    task automatic do_reset(input int cycles);
        rst        = 1'b1;
        inst_valid = 1'b0;
        for (int i = 0; i < cycles; i++) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_eq("rst_pc", pc, m_pc);
        check_eq("rst_halt", halt, 1'b0);
        check_eq("rst_illegal", illegal, 1'b0);
        check_eq("rst_retire", retire, 1'b0);
        check_eq("rst_req", imem_req, 1'b1);
    endtask

    task automatic run_inst(input logic [31:0] w, input int stalls);
        int          kind;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] val, npc, pc0;
        pc0 = m_pc;
        model_step(w, kind, rd, wr, val, npc);
        for (int s = 0; s < stalls; s++) begin
            check_eq("stall_pc", pc, pc0);
            check_eq("stall_retire", retire, 1'b0);
            inst_valid = 1'b0;
            inst       = $urandom;
            @(negedge clk);
        end
        check_eq("fetch_req", imem_req, 1'b1);
        check_eq("fetch_pc", pc, pc0);
        inst       = w;
        inst_valid = 1'b1;
        @(negedge clk);
        check_eq("decode_req", imem_req, 1'b0);
        check_eq("decode_retire", retire, 1'b0);
        inst       = $urandom;
        inst_valid = 1'($urandom);
        @(negedge clk);
        check_eq("exec_retire", retire, (kind == 0 || kind == 1));
        check_eq("exec_req", imem_req, 1'b0);
        inst       = $urandom;
        inst_valid = 1'($urandom);
        @(negedge clk);
        inst_valid = 1'b0;
        if (kind == 0) begin
            if (wr && rd != 5'd0) m_regs[rd] = val;
            m_pc = npc;
        end else begin
            m_halted  = 1'b1;
            m_illegal = (kind != 1);
        end
        check_eq("next_pc", pc, m_pc);
        check_eq("next_halt", halt, m_halted);
        check_eq("next_illegal", illegal, m_illegal);
        check_eq("next_retire", retire, 1'b0);
        check_eq("next_req", imem_req, !m_halted);
        dbg_check("rd_value", rd);
        dbg_check("x0_zero", 5'd0);
    endtask

    task automatic hold_halt(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            inst       = $urandom;
            inst_valid = 1'b1;
            @(negedge clk);
            check_eq("halt_pc", pc, m_pc);
            check_eq("halt_retire", retire, 1'b0);
            check_eq("halt_req", imem_req, 1'b0);
            check_eq("halt_sticky", halt, 1'b1);
        end
        inst_valid = 1'b0;
    endtask

    function automatic logic [31:0] enc_j(input int off, input logic [4:0] rd);
        logic [31:0] o;
        o = off;
        return {o[20], o[10:1], o[11], o[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        int          sel, off;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        f3  = 3'($urandom);
        imm = 12'($urandom);
        sel = int'($urandom_range(0, 39));
        if (sel == 0) return $urandom;
        if (sel < 5) return {20'($urandom), rd, (sel < 3) ? 7'h37 : 7'h17};
        if (sel < 9) begin
            off = (int'($urandom_range(0, 511)) - 256) * 4;
            if (sel == 8) off += 2;
            return enc_j(off, rd);
        end
        if (sel < 12) return {imm, rs1, 3'b000, rd, 7'h67};
        if (sel < 26) begin
            if (f3 == 3'd1) imm[11:5] = 7'h00;
            if (f3 == 3'd5) imm[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            return {imm, rs1, f3, rd, 7'h13};
        end
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1)) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    initial begin
        logic [31:0] v;
        rst        = 1'b1;
        inst       = 32'h0;
        inst_valid = 1'b0;
        dbg_addr   = 5'd0;
        model_reset();
        do_reset(2);
        for (int i = 0; i < 32; i++) dbg_check("rst_reg", 5'(i));

        // Directed scenarios with hand-derived constants
        run_inst(32'h0050_0093, 0);
        peek(5'd1, v);  check_eq("addi_x1", v, 32'd5);
        check_eq("addi_pc", pc, 32'h8000_0004);
        run_inst(32'hFFF0_0113, 1);
        run_inst(32'h0020_81B3, 0);
        peek(5'd2, v);  check_eq("addi_x2", v, 32'hFFFF_FFFF);
        peek(5'd3, v);  check_eq("add_wrap_x3", v, 32'd4);
        run_inst(32'h0070_0013, 0);
        peek(5'd0, v);  check_eq("x0_write_dropped", v, 32'd0);

        do_reset(1);
        run_inst(32'h0080_00EF, 0);
        peek(5'd1, v);  check_eq("jal_link", v, 32'h8000_0004);
        check_eq("jal_target", pc, 32'h8000_0008);
        run_inst(32'h1234_52B7, 5);
        peek(5'd5, v);  check_eq("lui_x5", v, 32'h1234_5000);

        // Randomized instruction stream with random fetch stalls
        for (int n = 0; n < 300; n++) begin
            if (m_halted) do_reset(1);
            run_inst(rand_inst(), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 32; i++) dbg_check("final_reg", 5'(i));

        // EBREAK: halt without illegal, retires once, then frozen
        if (m_halted) do_reset(1);
        run_inst(32'h0010_0073, 0);
        check_eq("ebreak_halt", halt, 1'b1);
        check_eq("ebreak_illegal", illegal, 1'b0);
        hold_halt(4);
        do_reset(1);

        // Load is unsupported: illegal halt, no retire
        run_inst(32'h0000_0003, 0);
        check_eq("load_halt", halt, 1'b1);
        check_eq("load_illegal", illegal, 1'b1);
        hold_halt(3);
        do_reset(1);

        // Reset while an instruction sits in DECODE
        run_inst(32'h0090_0313, 0);
        peek(5'd6, v);  check_eq("pre_rst_x6", v, 32'd9);
        check_eq("dec_fetch_pc", pc, m_pc);
        inst       = 32'h0013_0313;
        inst_valid = 1'b1;
        @(negedge clk);
        check_eq("dec_in_decode", imem_req, 1'b0);
        rst        = 1'b1;
        inst_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_eq("dec_rst_pc", pc, 32'h8000_0000);
        check_eq("dec_rst_req", imem_req, 1'b1);
        check_eq("dec_rst_halt", halt, 1'b0);
        check_eq("dec_rst_retire", retire, 1'b0);
        for (int i = 0; i < 32; i++) dbg_check("dec_rst_reg", 5'(i));
        repeat (2) begin
            @(negedge clk);
            check_eq("dec_rst_no_retire", retire, 1'b0);
            check_eq("dec_rst_pc_hold", pc, 32'h8000_0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
